// File: rtl/fb_pkg.sv
// Shared constants and state type for the trail framebuffer write scheduler.
package fb_pkg;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int BLK = 8;
  localparam logic [7:0] P1_ID = 8'h01;
  localparam logic [7:0] P2_ID = 8'h80;

  typedef enum logic {
    IDLE,
    CLEAR
  } fb_state_t;
endpackage

// File: rtl/fb_write_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; pointer remembers the last granted side.
module rr_arbiter2 (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic last_p2;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (1'b1)
        (req == 2'b11): gnt = last_p2 ? 2'b01 : 2'b10;
        (req == 2'b01): gnt = 2'b01;
        (req == 2'b10): gnt = 2'b10;
        default:        gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset)
      last_p2 <= 1'b1;
    else if (accept)
      last_p2 <= gnt[1];
  end
endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port owner: player round-robin plus full-frame clear.
// Define FB_SEED_START_EN to seed both start blocks during the clear sweep.
module fb_write_scheduler #(
  parameter int H_RES  = fb_pkg::H_RES,
  parameter int V_RES  = fb_pkg::V_RES,
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DATA_W = fb_pkg::DATA_W,
  parameter int BLK    = fb_pkg::BLK,
  parameter logic [DATA_W-1:0] P1_ID = fb_pkg::P1_ID,
  parameter logic [DATA_W-1:0] P2_ID = fb_pkg::P2_ID,
  parameter int P1_X = 216,
  parameter int P1_Y = 240,
  parameter int P2_X = 416,
  parameter int P2_Y = 240
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  input  logic              p2_valid,
  output logic              p2_ready,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [DATA_W-1:0] p2_data,
  output logic              addr_err,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic              wren
);
  import fb_pkg::*;

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam logic [ADDR_W-1:0] A_LAST =
    ADDR_W'(H_RES * V_RES - 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);

  fb_state_t state, state_nx;
  logic [ADDR_W-1:0] a;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0] gnt;
  logic arb_en;
  logic sweep_end;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] clr_data;

  assign arb_en = (state == IDLE) && !clear_req;

  rr_arbiter2 u_arb (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .en       (arb_en),
    .req      ({p2_valid, p1_valid}),
    .accept   (|gnt),
    .gnt      (gnt)
  );

  assign p1_ready   = gnt[0];
  assign p2_ready   = gnt[1];
  assign clear_busy = (state == CLEAR);
  assign sweep_end  = (a == A_LAST);
  assign sel_addr   = gnt[1] ? p2_addr : p1_addr;
  assign sel_data   = gnt[1] ? p2_data : p1_data;

`ifdef FB_SEED_START_EN
  logic [31:0] xe, ye;
  logic in1, in2;
  assign xe  = 32'(x);
  assign ye  = 32'(y);
  assign in1 = (xe >= 32'(P1_X)) && (xe < 32'(P1_X + BLK)) &&
               (ye >= 32'(P1_Y)) && (ye < 32'(P1_Y + BLK));
  assign in2 = (xe >= 32'(P2_X)) && (xe < 32'(P2_X + BLK)) &&
               (ye >= 32'(P2_Y)) && (ye < 32'(P2_Y + BLK));
  assign clr_data = in1 ? P1_ID : (in2 ? P2_ID : '0);
`else
  logic unused_cfg;
  assign unused_cfg = ^{y, P1_ID, P2_ID, 32'(BLK),
                        32'(P1_X), 32'(P1_Y),
                        32'(P2_X), 32'(P2_Y)};
  assign clr_data = '0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (clear_req) state_nx = CLEAR;
      CLEAR: if (sweep_end) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // x/y track a so the seed compare needs no divider or multiplier
  always_ff @(posedge CLOCK_50) begin
    if (reset || state != CLEAR || sweep_end) begin
      a <= '0;
      x <= '0;
      y <= '0;
    end else begin
      a <= a + 1'b1;
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wren       <= 1'b0;
      wraddress  <= '0;
      data       <= '0;
      addr_err   <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      wren       <= 1'b0;
      addr_err   <= 1'b0;
      clear_done <= 1'b0;
      if (state == CLEAR) begin
        wren       <= 1'b1;
        wraddress  <= a;
        data       <= clr_data;
        clear_done <= sweep_end;
      end else if (|gnt) begin
        if (sel_addr <= A_LAST) begin
          wren      <= 1'b1;
          wraddress <= sel_addr;
          data      <= sel_data;
        end else begin
          addr_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench: full-size instance for player traffic and aborted sweep,
// reduced-resolution instance for a complete clear sweep.
module tb_fb_write_scheduler;
  localparam int SH = 64;
  localparam int SV = 48;
  localparam int SD = SH * SV;

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic b_reset, b_clr, b_v1, b_v2;
  logic [18:0] b_a1, b_a2;
  logic [7:0] b_d1, b_d2;
  logic b_busy, b_done, b_r1, b_r2, b_err, b_wren;
  logic [18:0] b_wa;
  logic [7:0] b_wd;

  logic s_reset, s_clr, s_v1, s_v2;
  logic [18:0] s_a1, s_a2;
  logic [7:0] s_d1, s_d2;
  logic s_busy, s_done, s_r1, s_r2, s_err, s_wren;
  logic [18:0] s_wa;
  logic [7:0] s_wd;

  fb_write_scheduler u_big (
    .CLOCK_50(CLOCK_50), .reset(b_reset),
    .clear_req(b_clr), .clear_busy(b_busy),
    .clear_done(b_done),
    .p1_valid(b_v1), .p1_ready(b_r1),
    .p1_addr(b_a1), .p1_data(b_d1),
    .p2_valid(b_v2), .p2_ready(b_r2),
    .p2_addr(b_a2), .p2_data(b_d2),
    .addr_err(b_err), .wraddress(b_wa),
    .data(b_wd), .wren(b_wren)
  );

  fb_write_scheduler #(
    .H_RES(SH), .V_RES(SV),
    .P1_X(8), .P1_Y(16), .P2_X(40), .P2_Y(16)
  ) u_sm (
    .CLOCK_50(CLOCK_50), .reset(s_reset),
    .clear_req(s_clr), .clear_busy(s_busy),
    .clear_done(s_done),
    .p1_valid(s_v1), .p1_ready(s_r1),
    .p1_addr(s_a1), .p1_data(s_d1),
    .p2_valid(s_v2), .p2_ready(s_r2),
    .p2_addr(s_a2), .p2_data(s_d2),
    .addr_err(s_err), .wraddress(s_wa),
    .data(s_wd), .wren(s_wren)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  typedef struct {
    logic v1, v2;
    logic [18:0] a1, a2;
    logic [7:0] d1, d2;
    logic r1, r2, wren, err;
    logic [18:0] wa;
    logic [7:0] wd;
  } vec_t;

  function automatic vec_t mk(
    logic v1, logic v2,
    logic [18:0] a1, logic [7:0] d1,
    logic [18:0] a2, logic [7:0] d2,
    logic r1, logic r2, logic wren, logic err,
    logic [18:0] wa, logic [7:0] wd);
    vec_t t;
    t.v1 = v1; t.v2 = v2;
    t.a1 = a1; t.d1 = d1;
    t.a2 = a2; t.d2 = d2;
    t.r1 = r1; t.r2 = r2;
    t.wren = wren; t.err = err;
    t.wa = wa; t.wd = wd;
    return t;
  endfunction

  // expected seed content from pixel coordinates
  function automatic logic [7:0] exp_pix(int adr);
    int px, py;
    px = adr % SH;
    py = adr / SH;
`ifdef FB_SEED_START_EN
    if (px >= 8 && px < 16 && py >= 16 && py < 24)
      return 8'h01;
    if (px >= 40 && px < 48 && py >= 16 && py < 24)
      return 8'h80;
`endif
    return (px < 0 || py < 0) ? 8'hff : 8'h00;
  endfunction

  vec_t vt[10];
  int last_p2, g1, g2, sel, bad_a, bad_d, bad_r;
  int nexp, n01, n80, got_done, done_cnt;
  logic [18:0] ra1, ra2;
  logic [7:0] rd1, rd2;
  logic rv1, rv2;

  initial begin
    b_reset = 1; b_clr = 0; b_v1 = 0; b_v2 = 0;
    b_a1 = 0; b_a2 = 0; b_d1 = 0; b_d2 = 0;
    s_reset = 1; s_clr = 0; s_v1 = 0; s_v2 = 0;
    s_a1 = 0; s_a2 = 0; s_d1 = 0; s_d2 = 0;
    repeat (3) tick();
    b_reset = 0; s_reset = 0;
    #1;
    chk("rst_wren", b_wren, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_done", b_done, 0);
    chk("rst_err", b_err, 0);
    chk("rst_wa", b_wa, 0);
    chk("rst_wd", b_wd, 0);
    chk("rst_s_busy", s_busy, 0);

    vt[0] = mk(1,1, 10,8'h11, 20,8'h22, 1,0,1,0, 10,8'h11);
    vt[1] = mk(1,1, 10,8'h11, 20,8'h22, 0,1,1,0, 20,8'h22);
    vt[2] = mk(1,1, 10,8'h11, 20,8'h22, 1,0,1,0, 10,8'h11);
    vt[3] = mk(1,1, 10,8'h11, 20,8'h22, 0,1,1,0, 20,8'h22);
    vt[4] = mk(1,0, 153816,8'h01, 0,0, 1,0,1,0, 153816,8'h01);
    vt[5] = mk(0,1, 0,0, 307200,8'h55, 0,1,0,1, 0,0);
    vt[6] = mk(0,1, 0,0, 307199,8'h80, 0,1,1,0, 307199,8'h80);
    vt[7] = mk(0,0, 0,0, 0,0, 0,0,0,0, 0,0);
    vt[8] = mk(1,1, 1,8'h03, 2,8'h04, 1,0,1,0, 1,8'h03);
    vt[9] = mk(1,0, 524287,8'h09, 0,0, 1,0,0,1, 0,0);

    for (int i = 0; i < 10; i++) begin
      b_v1 = vt[i].v1; b_v2 = vt[i].v2;
      b_a1 = vt[i].a1; b_d1 = vt[i].d1;
      b_a2 = vt[i].a2; b_d2 = vt[i].d2;
      #1;
      chk($sformatf("vec%0d_r1", i), b_r1, vt[i].r1);
      chk($sformatf("vec%0d_r2", i), b_r2, vt[i].r2);
      tick();
      chk($sformatf("vec%0d_wren", i), b_wren, vt[i].wren);
      chk($sformatf("vec%0d_err", i), b_err, vt[i].err);
      if (vt[i].wren) begin
        chk($sformatf("vec%0d_wa", i), b_wa, vt[i].wa);
        chk($sformatf("vec%0d_wd", i), b_wd, vt[i].wd);
      end
    end
    b_v1 = 0; b_v2 = 0;

    b_reset = 1;
    tick();
    b_reset = 0;
    last_p2 = 1;
    for (int i = 0; i < 400; i++) begin
      rv1 = 1'($urandom_range(0, 1));
      rv2 = 1'($urandom_range(0, 1));
      ra1 = ($urandom_range(0, 7) == 0) ?
            19'($urandom_range(307200, 524287)) :
            19'($urandom_range(0, 307199));
      ra2 = ($urandom_range(0, 7) == 0) ?
            19'($urandom_range(307200, 524287)) :
            19'($urandom_range(0, 307199));
      rd1 = 8'($urandom);
      rd2 = 8'($urandom);
      b_v1 = rv1; b_v2 = rv2;
      b_a1 = ra1; b_a2 = ra2;
      b_d1 = rd1; b_d2 = rd2;
      g1 = (rv1 && (!rv2 || last_p2 == 1)) ? 1 : 0;
      g2 = (rv2 && (!rv1 || last_p2 == 0)) ? 1 : 0;
      #1;
      chk("rnd_r1", b_r1, g1);
      chk("rnd_r2", b_r2, g2);
      tick();
      if (g1 + g2 > 0) begin
        sel = (g2 == 1) ? int'(ra2) : int'(ra1);
        if (sel < 307200) begin
          chk("rnd_wren", b_wren, 1);
          chk("rnd_wa", b_wa, sel);
          chk("rnd_wd", b_wd, (g2 == 1) ? rd2 : rd1);
          chk("rnd_err0", b_err, 0);
        end else begin
          chk("rnd_wren_oor", b_wren, 0);
          chk("rnd_err1", b_err, 1);
        end
        last_p2 = g2;
      end else begin
        chk("rnd_idle_wren", b_wren, 0);
        chk("rnd_idle_err", b_err, 0);
      end
    end
    b_v1 = 0; b_v2 = 0;

    b_clr = 1; b_v2 = 1; b_a2 = 5;
    #1;
    chk("b_clr_r2", b_r2, 0);
    tick();
    chk("b_clr_busy", b_busy, 1);
    chk("b_clr_wren0", b_wren, 0);
    b_v2 = 0; b_v1 = 1; b_a1 = 7;
    bad_a = 0; bad_r = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!(b_wren && b_wa == 19'(i) && b_wd == 8'h00))
        bad_a++;
      if (b_r1 || b_r2 || !b_busy || b_done)
        bad_r++;
    end
    chk("b_sweep_seq", bad_a, 0);
    chk("b_sweep_ready0", bad_r, 0);
    b_reset = 1;
    tick();
    chk("abort_wren", b_wren, 0);
    chk("abort_busy", b_busy, 0);
    chk("abort_done", b_done, 0);
    b_clr = 0; b_v1 = 0;
    b_reset = 0;
    done_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (b_done || b_busy) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    b_v1 = 1;
    #1;
    chk("abort_idle_r1", b_r1, 1);
    b_v1 = 0;

    s_clr = 1; s_v2 = 1; s_a2 = 9;
    #1;
    chk("s_clr_r2", s_r2, 0);
    tick();
    chk("s_clr_busy", s_busy, 1);
    s_clr = 0; s_v2 = 0;
    s_v1 = 1; s_a1 = 100; s_d1 = 8'h5a;
    nexp = 0; n01 = 0; n80 = 0;
    bad_a = 0; bad_d = 0; bad_r = 0; got_done = 0;
    for (int i = 0; i < SD + 100; i++) begin
      tick();
      if (s_wren) begin
        if (s_wa != 19'(nexp)) bad_a++;
        if (s_wd != exp_pix(nexp)) bad_d++;
        if (s_wd == 8'h01) n01++;
        if (s_wd == 8'h80) n80++;
        nexp++;
      end
      if (s_busy && s_r1) bad_r++;
      if (s_done) begin
        got_done = 1;
        chk("s_done_busy", s_busy, 0);
        chk("s_done_r1", s_r1, 1);
        break;
      end
    end
    chk("s_got_done", got_done, 1);
    chk("s_nwrites", nexp, SD);
    chk("s_addr_seq", bad_a, 0);
    chk("s_data", bad_d, 0);
    chk("s_ready0", bad_r, 0);
`ifdef FB_SEED_START_EN
    chk("s_n01", n01, 64);
    chk("s_n80", n80, 64);
`else
    chk("s_n01", n01, 0);
    chk("s_n80", n80, 0);
`endif
    tick();
    chk("s_post_wren", s_wren, 1);
    chk("s_post_wa", s_wa, 100);
    chk("s_post_wd", s_wd, 8'h5a);
    chk("s_done_pulse", s_done, 0);
    s_v1 = 0;
    tick();
    chk("s_idle_wren", s_wren, 0);
    chk("s_idle_busy", s_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/fb_write_scheduler.md
# fb_write_scheduler

Owns the single write port of the 640x480x8 trail framebuffer RAM, which is clocked by CLOCK_50. It shares that port between two player write requesters using round-robin arbitration. On request, it runs a full-frame clear sweep that has priority over both players, and optionally seeds each player's 8x8 start block during the sweep. Its outputs drive the RAM's `wraddress`/`data`/`wren` directly. The read port (VGA_CLK domain) is outside this block.

## Interface
Parameters:
- `H_RES`, 640: visible width in pixels.
- `V_RES`, 480: visible height in pixels.
- `ADDR_W`, 19: framebuffer address width.
- `DATA_W`, 8: framebuffer word width.
- `BLK`, 8: start-block edge length in pixels.
- `P1_ID`, 8'h01: player 1 trail code.
- `P2_ID`, 8'h80: player 2 trail code.
- `P1_X`, 216 / `P1_Y`, 240: player 1 start block, top-left corner.
- `P2_X`, 416 / `P2_Y`, 240: player 2 start block, top-left corner.

Ports:
- `CLOCK_50`  in  1  system clock; also the RAM write clock.
- `reset`  in  1  synchronous, active-high.
- `clear_req`  in  1  start a clear sweep. Sampled only in IDLE.
- `clear_busy`  out  1  high while state is CLEAR.
- `clear_done`  out  1  one-cycle pulse after the last clear write.
- `p1_valid`  in  1  / `p1_ready`  out  1  player 1 write handshake.
- `p1_addr`  in  ADDR_W  / `p1_data`  in  DATA_W  player 1 write address and word.
- `p2_valid`, `p2_ready`, `p2_addr`, `p2_data`: same as player 1, for player 2.
- `addr_err`  out  1  one-cycle pulse when an out-of-range player write is dropped.
- `wraddress`  out  ADDR_W  RAM write address (registered).
- `data`  out  DATA_W  RAM write data (registered).
- `wren`  out  1  RAM write enable (registered).

## Operation
- FSM states: IDLE and CLEAR. Reset state is IDLE.
- Reset values: all outputs 0, including `wren`, `clear_busy`, `clear_done` and `addr_err`. The round-robin pointer resets to "last = P2", so P1 wins the first tie.
- IDLE with `clear_req=1`: go to CLEAR. Both `pN_ready` are 0 in that cycle, so `clear_req` beats any player request on the same edge.
- IDLE with `clear_req=0`: arbitrate between the players.
  - Only one `pN_valid` high: that requester gets `pN_ready=1`.
  - Both high: the requester not granted last gets ready.
  - The pointer updates only on a completed transfer (`valid && ready`).
  - `ready` is combinational from state, `clear_req`, both `valid`s and the pointer.
- Accepted write with `addr < H_RES*V_RES`: register `wraddress`/`data`, with `wren=1` for one cycle.
- Accepted write with `addr >= 307200`: the request is still consumed (ready is high), `wren=0`, and `addr_err` pulses.
- CLEAR sweep:
  - A linear counter `a` runs 0..307199, with an x counter (0..H_RES-1) and a y counter (0..V_RES-1) kept alongside.
  - One write per cycle, `wren=1`, data 0 (see Configuration).
  - The x counter wraps at 639 and increments y. No multiplier is used.
- While in CLEAR: both `pN_ready=0`, and `clear_req` is ignored. The sweep cannot be restarted or extended.
- After the write of address 307199 is registered: state returns to IDLE, counters go to 0, and `clear_done` pulses.
- `reset` mid-sweep: abort immediately, all outputs go to 0, state goes to IDLE. RAM contents are then undefined until the next sweep.

## Timing
- Player write latency: handshake at edge N; `wren`/`wraddress`/`data` valid in the cycle after edge N. The port sustains 1 write per cycle, alternating between players when both stream.
- Clear timing:
  - `clear_req` sampled at edge N sets `clear_busy` after edge N.
  - Clear writes for addresses 0..307199 are registered at edges N+1..N+307200.
  - At edge N+307200, `clear_busy` drops and `clear_done=1` for that single cycle.
  - Players may handshake in that same cycle.
- Sweep duration: 307200 cycles, 6.144 ms at 50 MHz.
- Starvation bound: a continuously valid player waits at most 1 cycle while the other player also streams. The bound excludes time spent in CLEAR.

## Configuration
- `FB_SEED_START_EN` defined:
  - During CLEAR, writes `P1_ID` to pixels with `P1_X <= x < P1_X+BLK` and `P1_Y <= y < P1_Y+BLK`.
  - Writes `P2_ID` to the P2 block in the same way.
  - Writes 0 everywhere else.
  - If the blocks overlap, P1 wins.
- `FB_SEED_START_EN` undefined: the sweep writes 0 to every address. The block-compare logic is absent.

## Structure
- Package `fb_pkg` holds:
  - `H_RES`, `V_RES`, `FB_DEPTH` = 307200.
  - `ADDR_W`, `DATA_W`.
  - `P1_ID`, `P2_ID`.
  - The state enum `fb_state_t` {IDLE, CLEAR}.
- Sub-module `rr_arbiter2`:
  - Inputs: two requests and an enable.
  - Outputs: a one-hot grant.
  - Its pointer advances on an `accept` input.
- The top level contains the FSM, the clear counters, the optional seed compare and the output registers.

## Test plan
- Reset, then `p1_valid=1`, `p1_addr=216+240*640`, `p1_data=8'h01` -> `p1_ready=1`; next cycle `wren=1`, `wraddress=153816`, `data=8'h01`.
- `p1_valid=p2_valid=1` held for 4 cycles -> grants go P1, P2, P1, P2; `wren` is high for 4 consecutive cycles.
- In IDLE, `clear_req=1` together with `p2_valid=1` -> `p2_ready=0`. Then exactly 307200 `wren` cycles, addresses 0..307199 in order, followed by `clear_done` for 1 cycle.
- Sweep with `FB_SEED_START_EN` defined -> exactly 64 writes of 8'h01 (the 64 addresses from 153816 through 158296 + 7) and 64 writes of 8'h80 at the P2 block. Without the macro, all 307200 writes are 0.
- `p2_addr=307200` accepted -> `p2_ready=1`, `wren=0`, `addr_err` pulses once.
- `reset` asserted at sweep cycle 1000 -> the next cycle has `wren=0`, `clear_busy=0`, state IDLE, and `clear_done` never pulses.
